// File: rtl/mmio_responder.sv
`timescale 1ns/1ps
// mmio_responder: load/store responder for the I/O window of the data port.
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   req_valid_i/req_we_i     request strobe and direction (1 = store)
//   addr_i/wdata_i/bmask_i   word address (bits [1:0] ignored), lane-aligned data, byte enables
//   rsp_valid_o/rdata_o/err_o registered response one cycle after each request
//   io_sw_i, io_key_i        raw asynchronous switches and active-low keys
//   io_ledr_o .. io_lcd7_o   byte-maskable output registers
// Word map (offset from BASE_ADDR): 0x000 LEDR, 0x010 LEDG, 0x020+4i HEXi,
// 0x040+4i LCDi, 0x800 SW (RO), 0x810 KEY (RO), 0x814 KEY_EVT (W1C).

// Per-key debouncer. sync_i is the synchronized key, active-high pressed.
// press_o is high in the cycle the accepted state goes released->pressed.
module mmio_key_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sync_i,
  output logic state_o,
  output logic press_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

  logic [CW-1:0] cnt;
  logic          differ;
  logic          flip;

  assign differ  = sync_i ^ state_o;
  // The counter holds the number of differing samples already seen, so the
  // flip lands on the DEBOUNCE_CYCLES-th consecutive differing sample.
  assign flip    = differ && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign press_o = flip && !state_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt     <= '0;
      state_o <= 1'b0;
    end else if (flip) begin
      cnt     <= '0;
      state_o <= ~state_o;
    end else if (differ) begin
      cnt     <= cnt + 1'b1;
    end else begin
      cnt     <= '0;
    end
  end
endmodule

module mmio_responder #(
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter logic [15:0] BASE_ADDR       = 16'h7000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [15:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  bmask_i,
  output logic        rsp_valid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  input  logic [31:0] io_sw_i,
  input  logic [3:0]  io_key_i,
  output logic [31:0] io_ledr_o,
  output logic [31:0] io_ledg_o,
  output logic [31:0] io_hex0_o,
  output logic [31:0] io_hex1_o,
  output logic [31:0] io_hex2_o,
  output logic [31:0] io_hex3_o,
  output logic [31:0] io_hex4_o,
  output logic [31:0] io_hex5_o,
  output logic [31:0] io_hex6_o,
  output logic [31:0] io_hex7_o,
  output logic [31:0] io_lcd0_o,
  output logic [31:0] io_lcd1_o,
  output logic [31:0] io_lcd2_o,
  output logic [31:0] io_lcd3_o,
  output logic [31:0] io_lcd4_o,
  output logic [31:0] io_lcd5_o,
  output logic [31:0] io_lcd6_o,
  output logic [31:0] io_lcd7_o
);
  localparam int NUM_KEYS = 4;

  function automatic logic [31:0] merge(input logic [31:0] old_v,
                                        input logic [31:0] new_v,
                                        input logic [3:0]  m);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++)
      if (m[i]) r[8*i +: 8] = new_v[8*i +: 8];
    return r;
  endfunction

  // ---------------- decode ----------------
  logic [9:0] widx;
  logic       sel;
  logic       hit_ledr, hit_ledg, hit_hex, hit_lcd, hit_sw, hit_key, hit_evt;
  logic       hit_rw, mapped, wr;
  logic       unused_addr_bits;

  assign unused_addr_bits = ^addr_i[1:0];
  assign widx     = addr_i[11:2];
  assign sel      = (addr_i[15:12] == BASE_ADDR[15:12]);
  assign hit_ledr = sel && (widx == 10'h000);
  assign hit_ledg = sel && (widx == 10'h004);
  assign hit_hex  = sel && (widx[9:3] == 7'h01);   // 0x020..0x03C
  assign hit_lcd  = sel && (widx[9:3] == 7'h02);   // 0x040..0x05C
  assign hit_sw   = sel && (widx == 10'h200);
  assign hit_key  = sel && (widx == 10'h204);
  assign hit_evt  = sel && (widx == 10'h205);
  assign hit_rw   = hit_ledr | hit_ledg | hit_hex | hit_lcd;
  assign mapped   = hit_rw | hit_sw | hit_key | hit_evt;
  assign wr       = req_valid_i && req_we_i;

  // ---------------- input synchronizers ----------------
  logic [31:0]         sw_s1, sw_s2;
  logic [NUM_KEYS-1:0] key_s1, key_s2;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      key_s1 <= '0;
      key_s2 <= '0;
    end else begin
      sw_s1  <= io_sw_i;
      sw_s2  <= sw_s1;
      key_s1 <= io_key_i;
      key_s2 <= key_s1;
    end
  end

  // ---------------- debounce, active-high pressed ----------------
  logic [NUM_KEYS-1:0] key_db;
  logic [NUM_KEYS-1:0] key_press;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    mmio_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .sync_i  (~key_s2[k]),
      .state_o (key_db[k]),
      .press_o (key_press[k])
    );
  end

  // ---------------- KEY_EVT: sticky, W1C, set beats clear ----------------
  logic [NUM_KEYS-1:0] key_evt;
  logic [NUM_KEYS-1:0] evt_clr;

  assign evt_clr = (wr && hit_evt && bmask_i[0]) ? wdata_i[NUM_KEYS-1:0] : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) key_evt <= '0;
    else         key_evt <= (key_evt & ~evt_clr) | key_press;
  end

  // ---------------- output registers ----------------
  logic [31:0]      ledr_q, ledg_q;
  logic [7:0][31:0] hex_q, lcd_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ledr_q <= '0;
      ledg_q <= '0;
      hex_q  <= '0;
      lcd_q  <= '0;
    end else if (wr) begin
      if (hit_ledr) ledr_q <= merge(ledr_q, wdata_i, bmask_i);
      if (hit_ledg) ledg_q <= merge(ledg_q, wdata_i, bmask_i);
      if (hit_hex)  hex_q[widx[2:0]] <= merge(hex_q[widx[2:0]], wdata_i, bmask_i);
      if (hit_lcd)  lcd_q[widx[2:0]] <= merge(lcd_q[widx[2:0]], wdata_i, bmask_i);
    end
  end

  // ---------------- read mux and response ----------------
  logic [31:0] rd_val;

  always_comb begin
    rd_val = '0;
    if      (hit_ledr) rd_val = ledr_q;
    else if (hit_ledg) rd_val = ledg_q;
    else if (hit_hex)  rd_val = hex_q[widx[2:0]];
    else if (hit_lcd)  rd_val = lcd_q[widx[2:0]];
    else if (hit_sw)   rd_val = sw_s2;
    else if (hit_key)  rd_val = {{(32-NUM_KEYS){1'b0}}, key_db};
    else if (hit_evt)  rd_val = {{(32-NUM_KEYS){1'b0}}, key_evt};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_o <= 1'b0;
      err_o       <= 1'b0;
      rdata_o     <= '0;
    end else begin
      rsp_valid_o <= req_valid_i;
      err_o       <= req_valid_i && (req_we_i ? !(hit_rw || hit_evt) : !mapped);
      // Store responses leave rdata_o untouched.
      if (req_valid_i && !req_we_i) rdata_o <= rd_val;
    end
  end

  assign io_ledr_o = ledr_q;
  assign io_ledg_o = ledg_q;
  assign io_hex0_o = hex_q[0];
  assign io_hex1_o = hex_q[1];
  assign io_hex2_o = hex_q[2];
  assign io_hex3_o = hex_q[3];
  assign io_hex4_o = hex_q[4];
  assign io_hex5_o = hex_q[5];
  assign io_hex6_o = hex_q[6];
  assign io_hex7_o = hex_q[7];
  assign io_lcd0_o = lcd_q[0];
  assign io_lcd1_o = lcd_q[1];
  assign io_lcd2_o = lcd_q[2];
  assign io_lcd3_o = lcd_q[3];
  assign io_lcd4_o = lcd_q[4];
  assign io_lcd5_o = lcd_q[5];
  assign io_lcd6_o = lcd_q[6];
  assign io_lcd7_o = lcd_q[7];
endmodule

// File: tb/tb_mmio_responder.sv
`timescale 1ns/1ps
// Scoreboard bench for mmio_responder: the driver pushes the reference
// model's expected response per request; a negedge monitor pops and compares
// whenever a response is due one cycle after issue.
module tb_mmio_responder;
  logic        clk, rst_n;
  logic        req_valid, req_we;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic [3:0]  bmask;
  logic        rsp_valid, err;
  logic [31:0] rdata;
  logic [31:0] sw;
  logic [3:0]  key;
  logic [31:0] ledr_o, ledg_o;
  logic [31:0] hex_o [8];
  logic [31:0] lcd_o [8];

  mmio_responder #(.DEBOUNCE_CYCLES(16), .BASE_ADDR(16'h7000)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_we_i(req_we), .addr_i(addr),
    .wdata_i(wdata), .bmask_i(bmask),
    .rsp_valid_o(rsp_valid), .rdata_o(rdata), .err_o(err),
    .io_sw_i(sw), .io_key_i(key),
    .io_ledr_o(ledr_o), .io_ledg_o(ledg_o),
    .io_hex0_o(hex_o[0]), .io_hex1_o(hex_o[1]), .io_hex2_o(hex_o[2]), .io_hex3_o(hex_o[3]),
    .io_hex4_o(hex_o[4]), .io_hex5_o(hex_o[5]), .io_hex6_o(hex_o[6]), .io_hex7_o(hex_o[7]),
    .io_lcd0_o(lcd_o[0]), .io_lcd1_o(lcd_o[1]), .io_lcd2_o(lcd_o[2]), .io_lcd3_o(lcd_o[3]),
    .io_lcd4_o(lcd_o[4]), .io_lcd5_o(lcd_o[5]), .io_lcd6_o(lcd_o[6]), .io_lcd7_o(lcd_o[7])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit        err;
    bit [31:0] rdata;
    int        cyc;
    string     nm;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;

  // Reference model state: RW registers keyed by byte offset.
  bit [31:0] regs [int];
  bit [31:0] sw_m;
  bit [3:0]  key_m, evt_m;
  bit [31:0] last_rd;

  task automatic chk(input string nm, input bit [31:0] act, input bit [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit [31:0] rget(input int o);
    return regs.exists(o) ? regs[o] : 32'h0;
  endfunction

  task automatic model_reset();
    regs.delete();
    key_m = 0; evt_m = 0; last_rd = 0;
  endtask

  // Issue one request on the current negedge; returns on the next negedge.
  task automatic issue(input bit we, input bit [15:0] a, input bit [31:0] wd,
                       input bit [3:0] bm, input string nm);
    exp_t e;
    int   o;
    bit   sel, rw, ro_sw, ro_key, ev;
    bit [31:0] v;
    o      = int'({a[11:2], 2'b00});
    sel    = (a[15:12] == 4'h7);
    rw     = sel && (o == 0 || o == 'h10 || (o >= 'h20 && o <= 'h5C));
    ro_sw  = sel && (o == 'h800);
    ro_key = sel && (o == 'h810);
    ev     = sel && (o == 'h814);
    if (we) begin
      e.err   = !(rw || ev);
      e.rdata = last_rd;
      if (rw) begin
        v = rget(o);
        for (int i = 0; i < 4; i++) if (bm[i]) v[8*i +: 8] = wd[8*i +: 8];
        regs[o] = v;
      end
      if (ev && bm[0]) evt_m = evt_m & ~wd[3:0];
    end else begin
      e.err = !(rw || ro_sw || ro_key || ev);
      if (rw)          e.rdata = rget(o);
      else if (ro_sw)  e.rdata = sw_m;
      else if (ro_key) e.rdata = {28'h0, key_m};
      else if (ev)     e.rdata = {28'h0, evt_m};
      else             e.rdata = 32'h0;
      last_rd = e.rdata;
    end
    e.cyc = cyc;
    e.nm  = nm;
    q.push_back(e);
    req_valid = 1'b1; req_we = we; addr = a; wdata = wd; bmask = bm;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0; req_we = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: a response is due exactly one cycle after its request.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (q.size() > 0 && q[0].cyc + 1 == cyc) begin
        e = q.pop_front();
        chk({e.nm, "_valid"}, rsp_valid, 1);
        chk({e.nm, "_err"},   err,       e.err);
        chk({e.nm, "_rdata"}, rdata,     e.rdata);
      end else begin
        chk("idle_rsp_valid", rsp_valid, 0);
        chk("idle_err",       err,       0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic bit [15:0] pick_mapped(input int idx);
    int off;
    if (idx == 0)       off = 'h000;
    else if (idx == 1)  off = 'h010;
    else if (idx < 10)  off = 'h020 + 4 * (idx - 2);
    else if (idx < 18)  off = 'h040 + 4 * (idx - 10);
    else if (idx == 18) off = 'h800;
    else if (idx == 19) off = 'h810;
    else                off = 'h814;
    return 16'h7000 | 16'(off);
  endfunction

  initial begin
    bit [15:0] a;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; addr = '0; wdata = '0; bmask = '0;
    key = 4'hF;
    sw = $urandom; sw_m = sw;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(5);

    // LED writes, then reset mid-run
    issue(1, 16'h7000, 32'hDEADBEEF, 4'hF, "st_ledr");
    chk("ledr_out", ledr_o, 32'hDEADBEEF);
    issue(1, 16'h7010, 32'h12345678, 4'hF, "st_ledg");
    issue(0, 16'h7000, 32'h0, 4'h0, "ld_ledr");
    idle(2);
    // A request in flight when reset hits must never respond.
    req_valid = 1'b1; req_we = 1'b0; addr = 16'h7000;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rdata",     rdata,     0);
    chk("rst_err",       err,       0);
    chk("rst_ledr",      ledr_o,    0);
    chk("rst_ledg",      ledg_o,    0);
    chk("rst_hex0",      hex_o[0],  0);
    chk("rst_lcd7",      lcd_o[7],  0);
    q.delete();
    model_reset();
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);
    issue(0, 16'h7000, 32'h0, 4'h0, "ld_ledr_after_rst");

    // Byte-masked store to HEX3
    issue(1, 16'h702C, 32'hAABBCCDD, 4'b1111, "st_hex3_full");
    issue(1, 16'h702C, 32'h11223344, 4'b0101, "st_hex3_mask");
    chk("hex3_out", hex_o[3], 32'hAA22CC44);
    issue(1, 16'h702C, 32'hFFFFFFFF, 4'b0000, "st_hex3_nomask");
    issue(0, 16'h702C, 32'h0, 4'h0, "ld_hex3");

    // Back-to-back load/store/load on LEDG
    issue(0, 16'h7010, 32'h0, 4'h0, "ld_ledg_old");
    issue(1, 16'h7010, 32'hCAFEF00D, 4'hF, "st_ledg");
    chk("ledg_out", ledg_o, 32'hCAFEF00D);
    issue(0, 16'h7013, 32'h0, 4'h0, "ld_ledg_new");

    // Error cases
    issue(1, 16'h7800, 32'hFFFFFFFF, 4'hF, "st_sw");
    issue(0, 16'h7100, 32'h0, 4'h0, "ld_unmapped");
    issue(0, 16'h6000, 32'h0, 4'h0, "ld_other_window");
    issue(1, 16'h7810, 32'hF, 4'hF, "st_key");
    issue(0, 16'h7800, 32'h0, 4'h0, "ld_sw");

    // Short glitch on key0: rejected
    key[0] = 1'b0;
    idle(10);
    key[0] = 1'b1;
    idle(30);
    issue(0, 16'h7810, 32'h0, 4'h0, "ld_key_glitch");
    issue(0, 16'h7814, 32'h0, 4'h0, "ld_evt_glitch");

    // Held press: debounced state visible to loads accepted 2+16 edges later
    key[0] = 1'b0;
    for (int k = 0; k < 25; k++) begin
      key_m = (k >= 18) ? 4'h1 : 4'h0;
      issue(0, 16'h7810, 32'h0, 4'h0, $sformatf("ld_key_hold_k%0d", k));
    end
    evt_m = 4'h1;
    issue(0, 16'h7814, 32'h0, 4'h0, "ld_evt_set");
    issue(1, 16'h7814, 32'hF, 4'b1110, "st_evt_lane0_off");
    issue(0, 16'h7814, 32'h0, 4'h0, "ld_evt_kept");
    issue(1, 16'h7814, 32'h0, 4'hF, "st_evt_zero");
    issue(1, 16'h7814, 32'h1, 4'b0001, "st_evt_clr");
    issue(0, 16'h7814, 32'h0, 4'h0, "ld_evt_cleared");

    // Release: no event on the falling side
    key[0] = 1'b1;
    idle(25);
    key_m = 4'h0;
    issue(0, 16'h7810, 32'h0, 4'h0, "ld_key_released");
    issue(0, 16'h7814, 32'h0, 4'h0, "ld_evt_after_release");

    // New press with a clear landing on the same edge: set wins
    key[0] = 1'b0;
    idle(17);
    issue(1, 16'h7814, 32'h1, 4'b0001, "st_evt_clr_race");
    evt_m = 4'h1; key_m = 4'h1;
    issue(0, 16'h7814, 32'h0, 4'h0, "ld_evt_set_wins");
    issue(0, 16'h7810, 32'h0, 4'h0, "ld_key_pressed");
    key[0] = 1'b1;
    idle(25);
    key_m = 4'h0;

    // Randomized traffic against the model
    sw = $urandom; sw_m = sw;
    idle(4);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        idle(1);
      end else begin
        case ($urandom_range(0, 7))
          0, 1, 2, 3, 4: a = pick_mapped($urandom_range(0, 20)) | 16'($urandom_range(0, 3));
          5, 6:          a = 16'h7000 | 16'($urandom_range(0, 'hFFF));
          default:       a = 16'($urandom);
        endcase
        issue($urandom_range(0, 1) == 1, a, $urandom, 4'($urandom), "rnd");
      end
    end

    chk("final_ledr", ledr_o, rget('h000));
    chk("final_ledg", ledg_o, rget('h010));
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("final_hex%0d", i), hex_o[i], rget('h020 + 4 * i));
      chk($sformatf("final_lcd%0d", i), lcd_o[i], rget('h040 + 4 * i));
    end

    idle(1);
    for (int w = 0; w < 10 && q.size() > 0; w++) @(negedge clk);
    if (q.size() > 0) chk("drain_pending", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
